// File: rtl/gat_loader_pkg.sv
// Shared types and default geometry for the GAT BRAM loader.
// Optional checksum outputs are enabled with GAT_LOADER_CHECKSUM_EN.
package gat_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_H  = 3'd1,
    LD_NI = 3'd2,
    LD_W  = 3'd3,
    DONE  = 3'd4
  } ld_state_e;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_H_DATA_WIDTH    = 19;
  localparam int DEF_NODE_INFO_WIDTH = 20;
  localparam int DEF_H_DATA_DEPTH    = 242101;
  localparam int DEF_NODE_INFO_DEPTH = 13264;
  localparam int DEF_WEIGHT_DEPTH    = 22928;
  localparam int DEF_S_DATA_WIDTH    = 32;
  localparam int CSUM_W              = 32;

endpackage

// File: rtl/gat_bram_loader_if.sv
// Valid/ready word stream feeding the BRAM loader (DMA side is master).
interface gat_bram_loader_if
  import gat_loader_pkg::*;
#(
  parameter int S_DATA_WIDTH = DEF_S_DATA_WIDTH
);
  logic [S_DATA_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gat_bram_loader_wr_port.sv
// One BRAM write register stage: beat counter, registered write port,
// final-beat detect and sticky done flag for a single load phase.
module gat_bram_wr_port #(
  parameter int W     = 8,
  parameter int DEPTH = 22928,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          enter,
  input  logic          wr,
  input  logic [AW:0]   len_in,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  din,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic          done,
  output logic          empty,
  output logic          final_beat,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [AW:0]   len_q, len_d, cnt_q, cnt_d;
  logic [W-1:0]  din_q, din_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ena_q, ena_d, done_q, done_d;

  assign ovf        = len_in > DEPTH_L;
  assign empty      = (len_q == '0);
  assign final_beat = wr && !empty && (cnt_q == len_q - 1'b1);

  always_comb begin
    len_d  = len_q;
    cnt_d  = cnt_q;
    din_d  = din_q;
    addr_d = addr_q;
    ena_d  = 1'b0;
    done_d = done_q;
    if (clr) begin
      len_d  = ovf ? DEPTH_L : len_in;
      cnt_d  = '0;
      done_d = 1'b0;
    end
    if (wr) begin
      din_d  = wdata;
      addr_d = cnt_q[AW-1:0];
      ena_d  = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (final_beat) done_d = 1'b1;
    end
    // An empty phase is marked done on the same edge the FSM enters it.
    if (enter && (len_d == '0)) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      din_q  <= '0;
      addr_q <= '0;
      ena_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      din_q  <= din_d;
      addr_q <= addr_d;
      ena_q  <= ena_d;
      done_q <= done_d;
    end
  end

  assign din   = din_q;
  assign ena   = ena_q;
  assign wea   = ena_q;
  assign addra = addr_q;
  assign done  = done_q;

endmodule

// File: rtl/gat_bram_loader.sv
// Streams H data, node info and weights into the accelerator BRAMs in order.
// Define GAT_LOADER_CHECKSUM_EN to add per-phase 32-bit checksum outputs.
module gat_bram_loader
  import gat_loader_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int H_DATA_WIDTH     = DEF_H_DATA_WIDTH,
  parameter int NODE_INFO_WIDTH  = DEF_NODE_INFO_WIDTH,
  parameter int H_DATA_DEPTH     = DEF_H_DATA_DEPTH,
  parameter int NODE_INFO_DEPTH  = DEF_NODE_INFO_DEPTH,
  parameter int WEIGHT_DEPTH     = DEF_WEIGHT_DEPTH,
  parameter int S_DATA_WIDTH     = DEF_S_DATA_WIDTH,
  parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [H_DATA_ADDR_W:0]      h_len,
  input  logic [NODE_INFO_ADDR_W:0]   ni_len,
  input  logic [WEIGHT_ADDR_W:0]      w_len,
  gat_bram_loader_if.slave            s,
  output logic                        busy,
  output logic                        load_err,
  output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]       wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done
`ifdef GAT_LOADER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]           h_csum,
  output logic [CSUM_W-1:0]           ni_csum,
  output logic [CSUM_W-1:0]           w_csum
`endif
);

  ld_state_e state_q, state_d;
  logic      busy_q, busy_d, err_q, err_d;
  logic      s_ready_c, acc, start_acc, cur_final;
  logic      wr_h, wr_ni, wr_w, enter_ni, enter_w;
  logic      h_empty, ni_empty, w_empty, h_final, ni_final, w_final;
  logic      h_ovf, ni_ovf, w_ovf;

  // Ready is a pure decode of the registered state; empty phases never take a beat.
  always_comb begin
    s_ready_c = 1'b0;
    cur_final = 1'b0;
    case (state_q)
      LD_H:    begin s_ready_c = !h_empty;  cur_final = h_final;  end
      LD_NI:   begin s_ready_c = !ni_empty; cur_final = ni_final; end
      LD_W:    begin s_ready_c = !w_empty;  cur_final = w_final;  end
      default: ;
    endcase
  end

  assign s.s_ready = s_ready_c;
  assign acc       = s.s_valid && s_ready_c;
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign wr_h      = acc && (state_q == LD_H);
  assign wr_ni     = acc && (state_q == LD_NI);
  assign wr_w      = acc && (state_q == LD_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)                state_d = LD_H;
      LD_H:       if (h_empty || h_final)   state_d = LD_NI;
      LD_NI:      if (ni_empty || ni_final) state_d = LD_W;
      LD_W:       if (w_empty || w_final)   state_d = DONE;
      default:                              state_d = IDLE;
    endcase
    enter_ni = (state_d == LD_NI) && (state_q != LD_NI);
    enter_w  = (state_d == LD_W) && (state_q != LD_W);
    busy_d   = (state_d == LD_H) || (state_d == LD_NI) || (state_d == LD_W);
    err_d    = err_q;
    if (start_acc) err_d = h_ovf || ni_ovf || w_ovf;
    // Framing: s_last must coincide exactly with the count-derived final beat.
    if (acc && (s.s_last != cur_final)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign busy     = busy_q;
  assign load_err = err_q;

  gat_bram_wr_port #(.W(H_DATA_WIDTH), .DEPTH(H_DATA_DEPTH), .AW(H_DATA_ADDR_W)) u_h_port (
    .clk(clk), .rst(rst), .clr(start_acc), .enter(start_acc), .wr(wr_h), .len_in(h_len),
    .wdata(s.s_data[H_DATA_WIDTH-1:0]), .din(h_data_bram_din), .ena(h_data_bram_ena),
    .wea(h_data_bram_wea), .addra(h_data_bram_addra), .done(h_data_bram_load_done),
    .empty(h_empty), .final_beat(h_final), .ovf(h_ovf)
  );

  gat_bram_wr_port #(.W(NODE_INFO_WIDTH), .DEPTH(NODE_INFO_DEPTH), .AW(NODE_INFO_ADDR_W)) u_ni_port (
    .clk(clk), .rst(rst), .clr(start_acc), .enter(enter_ni), .wr(wr_ni), .len_in(ni_len),
    .wdata(s.s_data[NODE_INFO_WIDTH-1:0]), .din(h_node_info_bram_din), .ena(h_node_info_bram_ena),
    .wea(h_node_info_bram_wea), .addra(h_node_info_bram_addra), .done(h_node_info_bram_load_done),
    .empty(ni_empty), .final_beat(ni_final), .ovf(ni_ovf)
  );

  gat_bram_wr_port #(.W(DATA_WIDTH), .DEPTH(WEIGHT_DEPTH), .AW(WEIGHT_ADDR_W)) u_w_port (
    .clk(clk), .rst(rst), .clr(start_acc), .enter(enter_w), .wr(wr_w), .len_in(w_len),
    .wdata(s.s_data[DATA_WIDTH-1:0]), .din(wgt_bram_din), .ena(wgt_bram_ena),
    .wea(wgt_bram_wea), .addra(wgt_bram_addra), .done(wgt_bram_load_done),
    .empty(w_empty), .final_beat(w_final), .ovf(w_ovf)
  );

`ifdef GAT_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] h_csum_q, h_csum_d, ni_csum_q, ni_csum_d, w_csum_q, w_csum_d;

  // Sums update on the accept edge, so they are final when the done flag rises.
  always_comb begin
    h_csum_d  = h_csum_q;
    ni_csum_d = ni_csum_q;
    w_csum_d  = w_csum_q;
    if (start_acc) begin
      h_csum_d  = '0;
      ni_csum_d = '0;
      w_csum_d  = '0;
    end
    if (wr_h)  h_csum_d  = h_csum_q  + CSUM_W'(s.s_data[H_DATA_WIDTH-1:0]);
    if (wr_ni) ni_csum_d = ni_csum_q + CSUM_W'(s.s_data[NODE_INFO_WIDTH-1:0]);
    if (wr_w)  w_csum_d  = w_csum_q  + CSUM_W'(s.s_data[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_csum_q  <= '0;
      ni_csum_q <= '0;
      w_csum_q  <= '0;
    end else begin
      h_csum_q  <= h_csum_d;
      ni_csum_q <= ni_csum_d;
      w_csum_q  <= w_csum_d;
    end
  end

  assign h_csum  = h_csum_q;
  assign ni_csum = ni_csum_q;
  assign w_csum  = w_csum_q;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader; checksum step runs when GAT_LOADER_CHECKSUM_EN is defined.
module tb_gat_bram_loader;
  import gat_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] h_len = '0;
  logic [14:0] ni_len = '0;
  logic [15:0] w_len = '0;
  logic        busy, load_err;
  logic [18:0] h_din;
  logic [17:0] h_addra;
  logic [19:0] ni_din;
  logic [13:0] ni_addra;
  logic [7:0]  w_din;
  logic [14:0] w_addra;
  logic        h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
  logic        h_done, ni_done, w_done;
`ifdef GAT_LOADER_CHECKSUM_EN
  logic [31:0] h_csum, ni_csum, w_csum;
`endif

  int checks = 0;
  int failures = 0;

  gat_bram_loader_if #(.S_DATA_WIDTH(32)) sif ();

  gat_bram_loader dut (
    .clk(clk), .rst(rst), .start(start), .h_len(h_len), .ni_len(ni_len), .w_len(w_len),
    .s(sif), .busy(busy), .load_err(load_err),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea),
    .h_data_bram_addra(h_addra),
    .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena), .h_node_info_bram_wea(ni_wea),
    .h_node_info_bram_addra(ni_addra),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addra),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(ni_done),
    .wgt_bram_load_done(w_done)
`ifdef GAT_LOADER_CHECKSUM_EN
    , .h_csum(h_csum), .ni_csum(ni_csum), .w_csum(w_csum)
`endif
  );

  always #5 clk = ~clk;

  wire [2:0] ena_v  = {h_ena, ni_ena, w_ena};
  wire [2:0] wea_v  = {h_wea, ni_wea, w_wea};
  wire [2:0] done_v = {h_done, ni_done, w_done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int h, input int ni, input int w);
    h_len  = 19'(h);
    ni_len = 15'(ni);
    w_len  = 16'(w);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    tick();
  endtask

  task automatic idle();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", sif.s_ready, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_done", done_v, 3'b000);
    chk("rst_ena", ena_v, 3'b000);
    rst = 1'b0;
    tick();

    // 1: back-to-back 4/2/3 load
    do_start(4, 2, 3);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", sif.s_ready, 1'b1);
    for (int i = 0; i < 9; i++) begin
      d = 32'hDEAD_0000 | (32'(i) << 8) | 32'(i + 16);
      beat(d, (i == 3) || (i == 5) || (i == 8));
      if (i < 4) begin
        chk("t1_ena_h", ena_v, 3'b100);
        chk("t1_h_addr", h_addra, 64'(i));
        chk("t1_h_din", h_din, d & 32'h7FFFF);
      end else if (i < 6) begin
        chk("t1_ena_ni", ena_v, 3'b010);
        chk("t1_ni_addr", ni_addra, 64'(i - 4));
        chk("t1_ni_din", ni_din, d & 32'hFFFFF);
      end else begin
        chk("t1_ena_w", ena_v, 3'b001);
        chk("t1_w_addr", w_addra, 64'(i - 6));
        chk("t1_w_din", w_din, d & 32'hFF);
      end
      chk("t1_wea", wea_v, ena_v);
      chk("t1_done", done_v, {i >= 3, i >= 5, i >= 8});
      chk("t1_ready_after", sif.s_ready, i < 8);
      chk("t1_busy_after", busy, i < 8);
    end
    idle();
    tick();
    chk("t1_idle_ena", ena_v, 3'b000);
    chk("t1_done_hold", done_v, 3'b111);
    chk("t1_err", load_err, 1'b0);

    // 2: gapped valid with h_len = 2
    do_start(2, 1, 1);
    chk("t2_done_clr", done_v, 3'b000);
    beat(32'h0000_0111, 1'b0);
    chk("t2_b0_ena", ena_v, 3'b100);
    chk("t2_b0_addr", h_addra, 0);
    idle();
    tick();
    chk("t2_gap_ena", ena_v, 3'b000);
    chk("t2_gap_addr", h_addra, 0);
    beat(32'h0000_0222, 1'b1);
    chk("t2_b1_ena", ena_v, 3'b100);
    chk("t2_b1_addr", h_addra, 1);
    chk("t2_b1_din", h_din, 19'h00222);
    chk("t2_h_done", done_v, 3'b100);
    idle();
    tick();
    chk("t2_gap2_ena", ena_v, 3'b000);
    beat(32'h0000_0333, 1'b1);
    beat(32'h0000_0044, 1'b1);
    idle();
    chk("t2_done", done_v, 3'b111);
    chk("t2_busy", busy, 1'b0);
    chk("t2_err", load_err, 1'b0);

    // 3: empty node-info phase is skipped
    do_start(1, 0, 2);
    beat(32'h0000_0055, 1'b1);
    chk("t3_h_ena", ena_v, 3'b100);
    chk("t3_ni_done_on_entry", done_v, 3'b110);
    chk("t3_ni_not_ready", sif.s_ready, 1'b0);
    beat(32'h0000_00A1, 1'b0);
    chk("t3_skip_no_write", ena_v, 3'b000);
    chk("t3_w_ready", sif.s_ready, 1'b1);
    beat(32'h0000_00A1, 1'b0);
    chk("t3_w0_ena", ena_v, 3'b001);
    chk("t3_w0_addr", w_addra, 0);
    chk("t3_w0_din", w_din, 8'hA1);
    beat(32'h0000_00B2, 1'b1);
    idle();
    chk("t3_w1_addr", w_addra, 1);
    chk("t3_done", done_v, 3'b111);
    chk("t3_err", load_err, 1'b0);

    // 4: early s_last flags an error but the load runs to its count
    do_start(4, 1, 1);
    beat(32'h0000_1000, 1'b0);
    chk("t4_err_b0", load_err, 1'b0);
    beat(32'h0000_1001, 1'b1);
    chk("t4_err_b1", load_err, 1'b1);
    beat(32'h0000_1002, 1'b0);
    chk("t4_b2_ena", ena_v, 3'b100);
    beat(32'h0000_1003, 1'b1);
    chk("t4_b3_addr", h_addra, 3);
    chk("t4_h_done", done_v, 3'b100);
    beat(32'h0000_2000, 1'b1);
    beat(32'h0000_0030, 1'b1);
    idle();
    chk("t4_done", done_v, 3'b111);
    chk("t4_err_sticky", load_err, 1'b1);
    chk("t4_busy", busy, 1'b0);

    // 5: asynchronous reset in the middle of node-info loading
    do_start(1, 3, 1);
    chk("t5_err_clr", load_err, 1'b0);
    beat(32'h0000_0777, 1'b1);
    beat(32'h000A_BCDE, 1'b0);
    chk("t5_ni_ena", ena_v, 3'b010);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ready", sif.s_ready, 1'b0);
    chk("t5_rst_ena", ena_v, 3'b000);
    chk("t5_rst_done", done_v, 3'b000);
    chk("t5_rst_h_din", h_din, 0);
    chk("t5_rst_ni_din", ni_din, 0);
    tick();
    rst = 1'b0;
    tick();
    do_start(1, 1, 1);
    beat(32'h0000_0009, 1'b1);
    chk("t5_re_h_ena", ena_v, 3'b100);
    chk("t5_re_h_addr", h_addra, 0);
    chk("t5_re_h_din", h_din, 19'h9);
    beat(32'h0000_0008, 1'b1);
    chk("t5_re_ni_addr", ni_addra, 0);
    beat(32'h0000_0007, 1'b1);
    idle();
    chk("t5_re_done", done_v, 3'b111);
    chk("t5_re_err", load_err, 1'b0);

`ifdef GAT_LOADER_CHECKSUM_EN
    // 6: weight checksum ignores upper stream bits
    do_start(1, 1, 3);
    beat(32'h0000_0001, 1'b1);
    beat(32'h0000_0002, 1'b1);
    beat(32'h0000_AB01, 1'b0);
    beat(32'h0000_3402, 1'b0);
    chk("t6_w_not_done", w_done, 1'b0);
    beat(32'h1234_56FF, 1'b1);
    idle();
    chk("t6_w_done", w_done, 1'b1);
    chk("t6_w_csum", w_csum, 32'h0000_0102);
    chk("t6_h_csum", h_csum, 32'h0000_0001);
`endif

    // 7: length at depth is legal, above depth flags an error
    do_start(1, 1, 22928);
    chk("t7_at_depth_err", load_err, 1'b0);
    chk("t7_at_depth_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    do_start(1, 1, 30000);
    chk("t7_over_depth_err", load_err, 1'b1);
    chk("t7_over_depth_busy", busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
